// File: rtl/data_mem_sync.sv
// Synchronous data memory with post-reset fill sequencer, byte enables and range check.
// Optional per-byte even parity storage and read checking when DMEM_PARITY_EN is defined.
module data_mem_sync #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned INIT_MODE = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic                init_done
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_ready_q, req_ready_d;
   logic                init_done_q, init_done_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we_c;
   logic [IDX_W-1:0]    mem_idx_c;
   logic [NB-1:0]       mem_be_c;
   logic [DATA_W-1:0]   mem_wdata_c;
   logic [IDX_W-1:0]    req_idx_c;
   logic                in_range_c;
   logic [DATA_W-1:0]   rd_word_c;
   logic [DATA_W-1:0]   merged_c;
   logic                par_err_c;

`ifdef DMEM_PARITY_EN
   logic [NB-1:0]       par_q [DEPTH];
`endif

   assign req_idx_c  = IDX_W'(req_addr);
   assign in_range_c = ({1'b0, req_addr} < CNT_W'(DEPTH));
   assign rd_word_c  = mem_q[req_idx_c];

   // Byte-merge of the write data over the currently stored word.
   always_comb begin
      merged_c = rd_word_c;
      for (int k = 0; k < int'(NB); k++) begin
         if (req_be[k]) merged_c[8*k +: 8] = req_wdata[8*k +: 8];
      end
   end

`ifdef DMEM_PARITY_EN
   always_comb begin
      par_err_c = 1'b0;
      for (int k = 0; k < int'(NB); k++) begin
         if ((^rd_word_c[8*k +: 8]) != par_q[req_idx_c][k]) par_err_c = 1'b1;
      end
   end
`else
   assign par_err_c = 1'b0;
`endif

   // Next-state, fill sequencing and request handling.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      init_done_d = init_done_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      mem_we_c    = 1'b0;
      mem_idx_c   = IDX_W'(cnt_q);
      mem_be_c    = '0;
      mem_wdata_c = '0;

      case (state_q)
         S_INIT: begin
            mem_we_c    = 1'b1;
            mem_be_c    = '1;
            mem_wdata_c = (INIT_MODE == 1) ? DATA_W'(cnt_q) : '0;
            cnt_d       = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1)) begin
               state_d     = S_RUN;
               req_ready_d = 1'b1;
               init_done_d = 1'b1;
            end
         end
         S_RUN: begin
            if (req_valid && req_ready_q) begin
               rsp_valid_d = 1'b1;
               if (!in_range_c) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
               end else if (req_we) begin
                  mem_we_c    = 1'b1;
                  mem_idx_c   = req_idx_c;
                  mem_be_c    = req_be;
                  mem_wdata_c = req_wdata;
                  rsp_data_d  = merged_c;
                  rsp_err_d   = 1'b0;
               end else begin
                  rsp_data_d = rd_word_c;
                  rsp_err_d  = par_err_c;
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage array is not reset; the fill sequence rewrites every word.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int k = 0; k < int'(NB); k++) begin
            if (mem_be_c[k]) begin
               mem_q[mem_idx_c][8*k +: 8] <= mem_wdata_c[8*k +: 8];
`ifdef DMEM_PARITY_EN
               par_q[mem_idx_c][k] <= ^mem_wdata_c[8*k +: 8];
`endif
            end
         end
      end
   end

   assign req_ready = req_ready_q;
   assign init_done = init_done_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed testbench for data_mem_sync (DEPTH=200, INIT_MODE=1, 16-bit words).
module tb_data_mem_sync;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 200;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [1:0]        req_be = 2'b00;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              init_done;

   int tests = 0;
   int failed = 0;

   data_mem_sync #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_MODE(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .init_done(init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One request presented for exactly one clock edge; outputs sampled 1 ns after it.
   task automatic issue(input logic we, input logic [1:0] be, input logic [7:0] addr,
                        input logic [15:0] wd);
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Count edges until req_ready rises (bounded), noting any response during the fill.
   task automatic wait_ready(output int n, output logic saw_rsp);
      n = 0; saw_rsp = 1'b0;
      while (!req_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (rsp_valid) saw_rsp = 1'b1;
      end
   endtask

   task automatic test_reset;
      int n; logic saw;
      #2 rst_n = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_be = 2'b00; req_addr = 8'h05;
      #1;
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      tests++; if (init_done !== 1'b0) begin failed++; $display("FAIL reset_init_done: got %b want 0", init_done); end
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      tests++; if (rsp_data !== 16'h0000) begin failed++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
      tests++; if (rsp_err !== 1'b0) begin failed++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready(n, saw);
      tests++; if (n != 200) begin failed++; $display("FAIL fill_cycles: got %0d want 200", n); end
      tests++; if (init_done !== 1'b1) begin failed++; $display("FAIL init_done_with_ready: got %b want 1", init_done); end
      tests++; if (saw !== 1'b0) begin failed++; $display("FAIL rsp_during_init: got %b want 0", saw); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++; if (rsp_valid !== 1'b1) begin failed++; $display("FAIL read05_valid: got %b want 1", rsp_valid); end
      tests++; if (rsp_data !== 16'h0005) begin failed++; $display("FAIL read05_data: got %h want 0005", rsp_data); end
      tests++; if (rsp_err !== 1'b0) begin failed++; $display("FAIL read05_err: got %b want 0", rsp_err); end
   endtask

   task automatic test_back_to_back;
      issue(1'b1, 2'b11, 8'h10, 16'hBEEF);
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin failed++; $display("FAIL b2b_write_rsp: got v=%b %h want v=1 beef", rsp_valid, rsp_data); end
      issue(1'b0, 2'b00, 8'h10, 16'h0000);
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin failed++; $display("FAIL b2b_read_rsp: got v=%b %h want v=1 beef", rsp_valid, rsp_data); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0 || rsp_data !== 16'hBEEF) begin failed++; $display("FAIL idle_hold: got v=%b %h want v=0 beef", rsp_valid, rsp_data); end
   endtask

   task automatic test_byte_enable;
      issue(1'b1, 2'b00, 8'h20, 16'h1234);
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0020) begin failed++; $display("FAIL be00_rsp: got v=%b %h want v=1 0020", rsp_valid, rsp_data); end
      issue(1'b1, 2'b10, 8'h20, 16'hAB00);
      tests++; if (rsp_data !== 16'hAB20) begin failed++; $display("FAIL be10_rsp: got %h want ab20", rsp_data); end
      issue(1'b1, 2'b01, 8'h20, 16'hFFCD);
      tests++; if (rsp_data !== 16'hABCD) begin failed++; $display("FAIL be01_rsp: got %h want abcd", rsp_data); end
      issue(1'b0, 2'b11, 8'h20, 16'h0000);
      tests++; if (rsp_data !== 16'hABCD || rsp_err !== 1'b0) begin failed++; $display("FAIL be_readback: got %h err=%b want abcd err=0", rsp_data, rsp_err); end
   endtask

   task automatic test_out_of_range;
      issue(1'b0, 2'b00, 8'hC8, 16'h0000);
      tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin failed++; $display("FAIL oor_read: got v=%b err=%b %h want v=1 err=1 0000", rsp_valid, rsp_err, rsp_data); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin failed++; $display("FAIL oor_hold: got v=%b err=%b want v=0 err=1", rsp_valid, rsp_err); end
      issue(1'b1, 2'b11, 8'hC8, 16'hFFFF);
      tests++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin failed++; $display("FAIL oor_write: got err=%b %h want err=1 0000", rsp_err, rsp_data); end
      issue(1'b0, 2'b00, 8'hC7, 16'h0000);
      tests++; if (rsp_err !== 1'b0 || rsp_data !== 16'h00C7) begin failed++; $display("FAIL last_word: got err=%b %h want err=0 00c7", rsp_err, rsp_data); end
      issue(1'b0, 2'b00, 8'hFF, 16'h0000);
      tests++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin failed++; $display("FAIL oor_max: got err=%b %h want err=1 0000", rsp_err, rsp_data); end
   endtask

   task automatic test_reset_mid;
      int n; logic saw;
      rst_n = 1'b0; #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL mid_init_ready: got %b want 0", req_ready); end
      rst_n = 1'b0; #1;
      tests++; if (req_ready !== 1'b0 || init_done !== 1'b0) begin failed++; $display("FAIL init_abort: got rdy=%b done=%b want 0 0", req_ready, init_done); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready(n, saw);
      tests++; if (n != 200) begin failed++; $display("FAIL refill_cycles: got %0d want 200", n); end
      issue(1'b1, 2'b11, 8'h10, 16'h5555);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5555) begin failed++; $display("FAIL inflight_read: got v=%b %h want v=1 5555", rsp_valid, rsp_data); end
      rst_n = 1'b0; #1;
      tests++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || req_ready !== 1'b0) begin failed++; $display("FAIL run_reset: got v=%b %h rdy=%b want v=0 0000 rdy=0", rsp_valid, rsp_data, req_ready); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL run_reset_drop: got %b want 0", rsp_valid); end
      req_valid = 1'b0;
      rst_n = 1'b1;
      wait_ready(n, saw);
      tests++; if (n != 200 || saw !== 1'b0) begin failed++; $display("FAIL refill2: got n=%0d saw=%b want 200 0", n, saw); end
      issue(1'b0, 2'b00, 8'h10, 16'h0000);
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0010) begin failed++; $display("FAIL word10_reinit: got v=%b %h want v=1 0010", rsp_valid, rsp_data); end
   endtask

   task automatic test_parity;
`ifdef DMEM_PARITY_EN
      dut.par_q[8'h30][0] = ~dut.par_q[8'h30][0];
      issue(1'b0, 2'b00, 8'h30, 16'h0000);
      tests++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0030) begin failed++; $display("FAIL parity_detect: got err=%b %h want err=1 0030", rsp_err, rsp_data); end
      issue(1'b1, 2'b11, 8'h30, 16'h1357);
      issue(1'b0, 2'b00, 8'h30, 16'h0000);
      tests++; if (rsp_err !== 1'b0 || rsp_data !== 16'h1357) begin failed++; $display("FAIL parity_repair: got err=%b %h want err=0 1357", rsp_err, rsp_data); end
`else
      issue(1'b0, 2'b00, 8'h30, 16'h0000);
      tests++; if (rsp_err !== 1'b0 || rsp_data !== 16'h0030) begin failed++; $display("FAIL noparity_read: got err=%b %h want err=0 0030", rsp_err, rsp_data); end
`endif
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_byte_enable();
      test_out_of_range();
      test_parity();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
